crc_mem_req_ctrl: RTL and testbench

Request front-end that sits directly upstream of crc_code_faulty_memory. It accepts read/write requests from a host over a valid/ready interface and turns each one into the memory's single-cycle write/read pulse, including the fault-injection fields. It waits for mem_completed and returns one response per request. Reads that report a CRC error are re-issued up to MAX_RETRY times, and every errored attempt is counted in a saturating counter.

---
 rtl/crc_mem_pkg.sv | 27 ++
 rtl/crc_sat_counter.sv | 25 ++
 rtl/crc_mem_req_ctrl.sv | 162 ++++++++++++++++
 tb/tb_crc_mem_req_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_mem_pkg.sv
// Shared types and widths for the CRC memory request front-end.
package crc_mem_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned FAULT_W = 4;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RETRY_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Captured host request; also the source of the memory-side fields
    typedef struct packed {
        logic               write;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
        logic               fault_en;
        logic [FAULT_W-1:0] fault_addr;
        logic [BURST_W-1:0] burst_len;
    } mem_req_t;

endpackage

// File: rtl/crc_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module crc_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // Count up on inc, hold at all-ones, clear wins
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/crc_mem_req_ctrl.sv
// Host request front-end for crc_code_faulty_memory: issues one memory pulse
// per attempt, retries CRC-errored reads, times out silent operations and
// returns exactly one response per request.
module crc_mem_req_ctrl
    import crc_mem_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned TIMEOUT   = 32,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic                 req_fault_en,
    input  logic [FAULT_W-1:0]   req_fault_addr,
    input  logic [BURST_W-1:0]   req_burst_len,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_data,
    output logic                 rsp_error,
    output logic                 rsp_timeout,
    output logic [RETRY_W-1:0]   rsp_retries,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [DATA_W-1:0]    mem_data_in,
    output logic [ADDR_W-1:0]    mem_addr_in,
    output logic [FAULT_W-1:0]   mem_fault_addr,
    output logic [BURST_W-1:0]   mem_burst_len,
    output logic                 mem_fault_enable,
    input  logic                 mem_write_busy,
    input  logic                 mem_read_busy,
    input  logic                 mem_data_valid,
    input  logic                 mem_error_detected,
    input  logic                 mem_completed,
    input  logic [DATA_W-1:0]    mem_data_out,
    input  logic                 clear_stats,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [RETRY_W-1:0] MAX_RETRY_L = RETRY_W'(MAX_RETRY);
    localparam logic [TMO_W-1:0]   TIMEOUT_L   = TMO_W'(TIMEOUT);

    state_e             state_q;
    mem_req_t           req_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [RETRY_W-1:0] retries_q;

    logic               rd_err_c;
    logic               err_inc_c;
    logic [TMO_W-1:0]   tmo_inc_c;

    // Accept only from IDLE while the memory is quiet
    assign req_ready = !rst && (state_q == IDLE) && !mem_write_busy && !mem_read_busy;

    // A read is bad on CRC mismatch or when no data came back with completion
    assign rd_err_c  = mem_error_detected | ~mem_data_valid;
    assign err_inc_c = (state_q == WAIT) && mem_completed && !req_q.write && rd_err_c;
    assign tmo_inc_c = tmo_q + TMO_W'(1);

    // Memory-side fields come straight from the captured request
    assign mem_data_in      = req_q.wdata;
    assign mem_addr_in      = req_q.addr;
    assign mem_fault_addr   = req_q.fault_addr;
    assign mem_burst_len    = req_q.burst_len;
    assign mem_fault_enable = req_q.fault_en;
    assign rsp_retries      = retries_q;

    // Request sequencing: accept, pulse, wait/retry/timeout, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            tmo_q       <= '0;
            retries_q   <= '0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_q <= '{write:      req_write,
                                   addr:       req_addr,
                                   wdata:      req_wdata,
                                   fault_en:   req_fault_en,
                                   fault_addr: req_fault_addr,
                                   burst_len:  req_burst_len};
                        mem_write <= req_write;
                        mem_read  <= !req_write;
                        tmo_q     <= '0;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Counter is zero during the pulse cycle, so it tracks cycles since issue
                    tmo_q   <= tmo_inc_c;
                    state_q <= WAIT;
                end
                WAIT: begin
                    tmo_q <= tmo_inc_c;
                    if (mem_completed) begin
                        if (req_q.write) begin
                            rsp_data  <= '0;
                            rsp_error <= 1'b0;
                            rsp_valid <= 1'b1;
                            state_q   <= RESP;
                        end else if (rd_err_c && (retries_q < MAX_RETRY_L)) begin
                            // Re-issue without injection so a clean read can succeed
                            retries_q      <= retries_q + RETRY_W'(1);
                            req_q.fault_en <= 1'b0;
                            mem_read       <= 1'b1;
                            tmo_q          <= '0;
                            state_q        <= ISSUE;
                        end else begin
                            rsp_data  <= mem_data_out;
                            rsp_error <= rd_err_c;
                            rsp_valid <= 1'b1;
                            state_q   <= RESP;
                        end
                    end else if (tmo_inc_c == TIMEOUT_L) begin
                        rsp_timeout <= 1'b1;
                        rsp_error   <= 1'b0;
                        rsp_data    <= '0;
                        rsp_valid   <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        retries_q   <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Errored read attempts, saturating
    crc_sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (err_inc_c),
        .clr_i   (clear_stats),
        .count_o (err_count)
    );

endmodule

// File: tb/tb_crc_mem_req_ctrl.sv
// Self-checking bench for crc_mem_req_ctrl with a behavioural memory responder.
module tb_crc_mem_req_ctrl;
    import crc_mem_pkg::*;

    localparam int MAX_RETRY = 2;
    localparam int TIMEOUT   = 32;
    localparam int ERR_CNT_W = 16;

    logic clk, rst;
    logic req_valid, req_ready, req_write, req_fault_en;
    logic [3:0] req_addr, req_fault_addr;
    logic [7:0] req_wdata;
    logic [1:0] req_burst_len;
    logic rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [7:0] rsp_data;
    logic [1:0] rsp_retries;
    logic mem_write, mem_read, mem_fault_enable;
    logic [7:0] mem_data_in, mem_data_out;
    logic [3:0] mem_addr_in, mem_fault_addr;
    logic [1:0] mem_burst_len;
    logic mem_write_busy, mem_read_busy, mem_data_valid, mem_error_detected, mem_completed;
    logic clear_stats;
    logic [ERR_CNT_W-1:0] err_count;

    crc_mem_req_ctrl #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_fault_en(req_fault_en),
        .req_fault_addr(req_fault_addr), .req_burst_len(req_burst_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .rsp_retries(rsp_retries),
        .mem_write(mem_write), .mem_read(mem_read), .mem_data_in(mem_data_in),
        .mem_addr_in(mem_addr_in), .mem_fault_addr(mem_fault_addr),
        .mem_burst_len(mem_burst_len), .mem_fault_enable(mem_fault_enable),
        .mem_write_busy(mem_write_busy), .mem_read_busy(mem_read_busy),
        .mem_data_valid(mem_data_valid), .mem_error_detected(mem_error_detected),
        .mem_completed(mem_completed), .mem_data_out(mem_data_out),
        .clear_stats(clear_stats), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: mode 0 clean, 1 errors when fault_enable, 2 always errors, 3 never completes
    int mode = 0, lat = 1;
    logic [7:0] mem_arr [16];
    bit pend, p_write, p_fen, resp_err;
    int cnt;
    logic [3:0] p_addr;
    logic [7:0] p_data;
    int rd_pulses, wr_pulses, pulse_n;
    logic [3:0] first_addr, first_faddr;
    logic [7:0] first_data;
    logic [1:0] first_blen;
    logic first_fen;
    logic fen_log [4];
    int issue_cyc, first_issue_cyc, done_cyc;

    initial begin
        mem_completed = 0; mem_write_busy = 0; mem_read_busy = 0;
        mem_data_valid = 0; mem_error_detected = 0; mem_data_out = 0;
        pend = 0; cnt = 0; rd_pulses = 0; wr_pulses = 0; pulse_n = 0;
        for (int i = 0; i < 16; i++) mem_arr[i] = 8'h00;
        forever begin
            @(posedge clk); #1;
            mem_completed = 0;
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    pend = 0; mem_write_busy = 0; mem_read_busy = 0;
                    mem_completed = 1; done_cyc = cyc;
                    if (p_write) begin
                        mem_arr[p_addr] = p_data;
                        mem_data_valid = 0; mem_error_detected = 0;
                    end else begin
                        resp_err = (mode == 2) || (mode == 1 && p_fen);
                        mem_error_detected = resp_err;
                        mem_data_valid = 1;
                        mem_data_out = resp_err ? ~mem_arr[p_addr] : mem_arr[p_addr];
                    end
                end
            end
            if (mem_write || mem_read) begin
                if (mem_write) wr_pulses++; else rd_pulses++;
                if (pulse_n == 0) begin
                    first_addr = mem_addr_in; first_faddr = mem_fault_addr;
                    first_data = mem_data_in; first_blen = mem_burst_len;
                    first_fen = mem_fault_enable; first_issue_cyc = cyc;
                end
                if (pulse_n < 4) fen_log[pulse_n] = mem_fault_enable;
                pulse_n++;
                issue_cyc = cyc;
                p_write = mem_write; p_addr = mem_addr_in; p_data = mem_data_in; p_fen = mem_fault_enable;
                if (mode != 3) begin
                    pend = 1; cnt = lat;
                    mem_write_busy = mem_write; mem_read_busy = mem_read;
                end
            end
        end
    end

    int checks = 0, errors = 0;
    logic [ERR_CNT_W-1:0] ref_err;
    logic [7:0] ref_mem [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full request/response with expectations from the reference model
    task automatic txn(input string nm, input bit w, input logic [3:0] a, input logic [7:0] d,
                       input bit fen, input logic [3:0] fa, input logic [1:0] bl,
                       input int md, input int lt, input int hold);
        logic [7:0] e_data;
        bit e_err, e_tmo, aerr, done;
        int e_ret, e_pulses, att, n, rcyc, acc_cyc;
        logic [7:0] s_data;
        logic s_err, s_tmo;
        logic [1:0] s_ret;

        e_data = 0; e_err = 0; e_tmo = 0; e_ret = 0; e_pulses = 1;
        if (md == 3) begin
            e_tmo = 1;
        end else if (w) begin
            ref_mem[a] = d;
        end else begin
            att = 0; done = 0;
            while (!done) begin
                aerr = (md == 2) || (md == 1 && att == 0 && fen);
                if (aerr && ref_err != {ERR_CNT_W{1'b1}}) ref_err = ref_err + 1'b1;
                if (aerr && att < MAX_RETRY) begin
                    att++;
                end else begin
                    e_data = aerr ? ~ref_mem[a] : ref_mem[a];
                    e_err = aerr; done = 1;
                end
            end
            e_ret = att; e_pulses = att + 1;
        end

        mode = md; lat = lt; rd_pulses = 0; wr_pulses = 0; pulse_n = 0;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk({nm, ".ready"}, 32'(req_ready), 32'(1));
        req_write = w; req_addr = a; req_wdata = d; req_fault_en = fen;
        req_fault_addr = fa; req_burst_len = bl; req_valid = 1;
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        rcyc = cyc;
        chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'(1));
        chk({nm, ".data"}, 32'(rsp_data), 32'(e_data));
        chk({nm, ".error"}, 32'(rsp_error), 32'(e_err));
        chk({nm, ".timeout"}, 32'(rsp_timeout), 32'(e_tmo));
        chk({nm, ".retries"}, 32'(rsp_retries), 32'(e_ret));
        chk({nm, ".pulses"}, 32'(w ? wr_pulses : rd_pulses), 32'(e_pulses));
        chk({nm, ".other_pulses"}, 32'(w ? rd_pulses : wr_pulses), 32'(0));
        chk({nm, ".issue_lat"}, 32'(first_issue_cyc), 32'(acc_cyc + 1));
        chk({nm, ".mem_addr"}, 32'(first_addr), 32'(a));
        chk({nm, ".mem_fen"}, 32'(first_fen), 32'(fen));
        chk({nm, ".mem_faddr"}, 32'(first_faddr), 32'(fa));
        chk({nm, ".mem_blen"}, 32'(first_blen), 32'(bl));
        if (w) chk({nm, ".mem_wdata"}, 32'(first_data), 32'(d));
        for (int i = 1; i < e_pulses; i++) chk({nm, ".retry_fen"}, 32'(fen_log[i]), 32'(0));
        if (md == 3) chk({nm, ".tmo_lat"}, 32'(rcyc), 32'(issue_cyc + TIMEOUT));
        else         chk({nm, ".rsp_lat"}, 32'(rcyc), 32'(done_cyc + 1));

        s_data = rsp_data; s_err = rsp_error; s_tmo = rsp_timeout; s_ret = rsp_retries;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, ".hold_stable"},
                32'({rsp_valid, rsp_data, rsp_error, rsp_timeout, rsp_retries}),
                32'({1'b1, s_data, s_err, s_tmo, s_ret}));
            chk({nm, ".hold_ready"}, 32'(req_ready), 32'(0));
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk({nm, ".rsp_drop"}, 32'(rsp_valid), 32'(0));
        chk({nm, ".tmo_clear"}, 32'(rsp_timeout), 32'(0));
        chk({nm, ".err_count"}, 32'(err_count), 32'(ref_err));
    endtask

    initial begin
        int n, md;
        rst = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        req_fault_en = 0; req_fault_addr = 0; req_burst_len = 0;
        rsp_ready = 0; clear_stats = 0; ref_err = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outs",
            32'({req_ready, rsp_valid, rsp_error, rsp_timeout, rsp_retries, mem_write, mem_read,
                 mem_fault_enable, mem_addr_in, mem_fault_addr, mem_burst_len}), 32'(0));
        chk("reset_data", 32'({rsp_data, mem_data_in}), 32'(0));
        chk("reset_errcnt", 32'(err_count), 32'(0));
        rst = 0;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'(1));

        // Directed scenarios
        txn("wr_a5",     1, 4'd0, 8'hA5, 0, 4'd0, 2'd0, 0, 12, 0);
        txn("rd_a5",     0, 4'd0, 8'h00, 0, 4'd0, 2'd0, 0, 3,  0);
        txn("wr_3c",     1, 4'd1, 8'h3C, 0, 4'd0, 2'd0, 0, 2,  0);
        txn("rd_fault",  0, 4'd1, 8'h00, 1, 4'd3, 2'd0, 1, 4,  0);
        txn("rd_allerr", 0, 4'd1, 8'h00, 0, 4'd0, 2'd0, 2, 3,  0);
        clear_stats = 1;
        @(negedge clk);
        clear_stats = 0;
        ref_err = '0;
        chk("clear_stats", 32'(err_count), 32'(0));
        txn("timeout",   0, 4'd0, 8'h00, 0, 4'd0, 2'd0, 3, 1,  0);
        txn("after_tmo", 0, 4'd0, 8'h00, 0, 4'd0, 2'd0, 0, 2,  0);
        txn("backpress", 1, 4'd5, 8'h5A, 1, 4'd7, 2'd3, 0, 5,  5);

        // Randomized traffic
        for (int k = 0; k < 16; k++) begin
            md = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
            txn("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                md, int'($urandom_range(1, 8)), int'($urandom_range(0, 3)));
        end

        // Reset while waiting on a slow read; its late completion must be ignored
        mode = 0; lat = 20; pulse_n = 0; rd_pulses = 0; wr_pulses = 0;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        req_write = 0; req_addr = 4'd2; req_fault_en = 1; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("rst_wait_outs",
            32'({req_ready, rsp_valid, rsp_error, rsp_timeout, rsp_retries, mem_write, mem_read,
                 mem_fault_enable, mem_addr_in, mem_fault_addr, mem_burst_len}), 32'(0));
        chk("rst_wait_errcnt", 32'(err_count), 32'(0));
        ref_err = '0;
        rst = 0;
        rd_pulses = 0; wr_pulses = 0;
        repeat (25) @(negedge clk);
        chk("late_cmp_valid", 32'(rsp_valid), 32'(0));
        chk("late_cmp_pulses", 32'(rd_pulses + wr_pulses), 32'(0));
        chk("late_cmp_ready", 32'(req_ready), 32'(1));
        txn("post_rst",  0, 4'd1, 8'h00, 0, 4'd0, 2'd0, 0, 2,  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
